// File: rtl/fll_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fll_window_ctrl
// Purpose  : FLL measurement-window sequencer. Counts local edges per N master
//            edges and raises sticky speedup/slowdown interrupts with lock
//            detection, clear handshake and post-correction holdoff.
// Revision : 1.0
// ============================================================================
module fll_window_ctrl #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic             WB_CLK,
  input  logic             WB_RST,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] window_len_i,
  input  logic [7:0]       deadband_i,
  input  logic [CNT_W-1:0] holdoff_i,
  input  logic             master_edge_i,
  input  logic             local_edge_i,
  input  logic             int_clr_i,
  output logic             Interrupt_speedup_o,
  output logic             Interrupt_slowdown_o,
  output logic [CNT_W:0]   err_o,
  output logic             err_valid_o,
  output logic             locked_o,
  output logic [2:0]       state_o
);

  localparam int c_LK_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  c_ONE  = CNT_W'(1);
  localparam logic [c_LK_W-1:0] c_LOCK = c_LK_W'(LOCK_CNT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEASURE  = 3'd1,
    S_EVAL     = 3'd2,
    S_WAIT_CLR = 3'd3,
    S_HOLDOFF  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_m_cnt;
  logic [CNT_W-1:0]   r_l_cnt;
  logic [CNT_W-1:0]   r_ho_cnt;
  logic [CNT_W-1:0]   r_sh_len;
  logic [CNT_W-1:0]   r_sh_ho;
  logic [7:0]         r_sh_db;
  logic [CNT_W:0]     r_err;
  logic               r_err_valid;
  logic               r_slow;
  logic               r_speed;
  logic [c_LK_W-1:0]  r_lock_cnt;

  logic [CNT_W-1:0]   w_len_eff;
  logic [CNT_W-1:0]   w_len_m1;
  logic [CNT_W-1:0]   w_l_inc;
  logic [CNT_W-1:0]   w_l_final;
  logic               w_close;
  logic [CNT_W:0]     w_err;
  logic [CNT_W:0]     w_db;
  logic [CNT_W:0]     w_neg_db;
  logic               w_over;
  logic               w_under;
  logic               w_enter_meas;

  // A zero window length is treated as a one-edge window.
  assign w_len_eff = (r_sh_len == '0) ? c_ONE : r_sh_len;
  assign w_len_m1  = w_len_eff - c_ONE;
  assign w_l_inc   = (r_l_cnt == '1) ? r_l_cnt : (r_l_cnt + c_ONE);
  assign w_l_final = local_edge_i ? w_l_inc : r_l_cnt;
  assign w_close   = (r_state == S_MEASURE) && master_edge_i && (r_m_cnt == w_len_m1);
  assign w_err     = {1'b0, w_l_final} - {1'b0, w_len_eff};

  assign w_db      = {{(CNT_W + 1 - 8){1'b0}}, r_sh_db};
  assign w_neg_db  = -w_db;
  assign w_over    = $signed(r_err) > $signed(w_db);
  assign w_under   = $signed(r_err) < $signed(w_neg_db);

  always_comb begin
    w_next = r_state;
    if (!enable_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     w_next = S_MEASURE;
        S_MEASURE:  if (w_close) w_next = S_EVAL;
        S_EVAL:     w_next = (w_over || w_under) ? S_WAIT_CLR : S_MEASURE;
        S_WAIT_CLR: if (int_clr_i) w_next = S_HOLDOFF;
        S_HOLDOFF:  if (r_ho_cnt == r_sh_ho) w_next = S_MEASURE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  assign w_enter_meas = (w_next == S_MEASURE) && (r_state != S_MEASURE);

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      r_state     <= S_IDLE;
      r_m_cnt     <= '0;
      r_l_cnt     <= '0;
      r_ho_cnt    <= '0;
      r_sh_len    <= '0;
      r_sh_ho     <= '0;
      r_sh_db     <= '0;
      r_err       <= '0;
      r_err_valid <= 1'b0;
      r_slow      <= 1'b0;
      r_speed     <= 1'b0;
      r_lock_cnt  <= '0;
    end else begin
      r_state     <= w_next;
      r_err_valid <= 1'b0;
      if (!enable_i) begin
        r_slow     <= 1'b0;
        r_speed    <= 1'b0;
        r_lock_cnt <= '0;
        r_m_cnt    <= '0;
        r_l_cnt    <= '0;
      end else begin
        case (r_state)
          S_MEASURE: begin
            if (w_close) begin
              r_err       <= w_err;
              r_err_valid <= 1'b1;
            end else begin
              if (master_edge_i) r_m_cnt <= r_m_cnt + c_ONE;
              if (local_edge_i)  r_l_cnt <= w_l_inc;
            end
          end
          S_EVAL: begin
            if (w_over) begin
              r_slow     <= 1'b1;
              r_lock_cnt <= '0;
            end else if (w_under) begin
              r_speed    <= 1'b1;
              r_lock_cnt <= '0;
            end else if (r_lock_cnt != c_LOCK) begin
              r_lock_cnt <= r_lock_cnt + c_LK_W'(1);
            end
          end
          S_WAIT_CLR: begin
            if (int_clr_i) begin
              r_slow   <= 1'b0;
              r_speed  <= 1'b0;
              r_ho_cnt <= '0;
            end
          end
          S_HOLDOFF: r_ho_cnt <= r_ho_cnt + c_ONE;
          default: ;
        endcase
        // Configuration is frozen for the whole window it applies to.
        if (w_enter_meas) begin
          r_sh_len <= window_len_i;
          r_sh_db  <= deadband_i;
          r_sh_ho  <= holdoff_i;
          r_m_cnt  <= '0;
          r_l_cnt  <= '0;
        end
      end
    end
  end

  assign Interrupt_speedup_o  = r_speed;
  assign Interrupt_slowdown_o = r_slow;
  assign err_o                = r_err;
  assign err_valid_o          = r_err_valid;
  assign locked_o             = (r_lock_cnt == c_LOCK);
  assign state_o              = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fll_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fll_window_ctrl
// Purpose  : Self-checking bench for fll_window_ctrl: directed vector table,
//            abort/reset sequences and randomized windows vs. an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_fll_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] win_len;
  logic [7:0]  deadband;
  logic [15:0] holdoff;
  logic        master_edge;
  logic        local_edge;
  logic        int_clr;
  logic        speedup;
  logic        slowdown;
  logic [16:0] err;
  logic        err_valid;
  logic        locked;
  logic [2:0]  state;

  int n_tests = 0;
  int n_fail  = 0;
  int m_lock  = 0;

  always #5 clk = ~clk;

  fll_window_ctrl #(.CNT_W(16), .LOCK_CNT(4)) dut (
    .WB_CLK               (clk),
    .WB_RST               (rst),
    .enable_i             (enable),
    .window_len_i         (win_len),
    .deadband_i           (deadband),
    .holdoff_i            (holdoff),
    .master_edge_i        (master_edge),
    .local_edge_i         (local_edge),
    .int_clr_i            (int_clr),
    .Interrupt_speedup_o  (speedup),
    .Interrupt_slowdown_o (slowdown),
    .err_o                (err),
    .err_valid_o          (err_valid),
    .locked_o             (locked),
    .state_o              (state)
  );

  typedef struct {
    int len; int db; int ho; int nloc;
    bit coinc; bit eval_loc;
    int exp_err; int exp_int; bit exp_lock; int idle;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drives one full window while the DUT is in MEASURE; applies the next
  // window's configuration during the EVAL cycle.
  task automatic window(input int len, input int nloc, input bit coinc, input bit eval_loc,
                        input int nlen, input int ndb, input int nho,
                        input int exp_err, input int exp_int, input bit exp_lock);
    int le, n, off, q;
    bit loc;
    le  = (len == 0) ? 1 : len;
    n   = (2 * le > nloc) ? 2 * le : nloc;
    off = n - 2 * le;
    q   = nloc;
    for (int c = 0; c < n; c++) begin
      master_edge = (c >= off) && (((c - off) % 2) == 1);
      if (coinc) loc = (c >= n - nloc);
      else       loc = (q > 0) && (int'($urandom_range(n - c - 1, 0)) < q);
      if (loc) q--;
      local_edge = loc;
      int_clr    = ($urandom_range(5, 0) == 0);
      step();
    end
    master_edge = 1'b0;
    local_edge  = eval_loc;
    int_clr     = 1'b0;
    win_len     = 16'(nlen);
    deadband    = 8'(ndb);
    holdoff     = 16'(nho);
    check("eval_state", 32'(state), 32'd2);
    check("err", 32'(err), 32'(exp_err) & 32'h1FFFF);
    check("err_valid", 32'(err_valid), 32'd1);
    step();
    local_edge = 1'b0;
    check("post_state", 32'(state), (exp_int != 0) ? 32'd3 : 32'd1);
    check("slowdown", 32'(slowdown), 32'(exp_int == 1));
    check("speedup", 32'(speedup), 32'(exp_int == 2));
    check("locked", 32'(locked), 32'(exp_lock));
    check("err_valid_pulse", 32'(err_valid), 32'd0);
  endtask

  task automatic clear_seq(input int idle, input int ho, input int it);
    check("wait_state", 32'(state), 32'd3);
    for (int k = 0; k < idle; k++) begin
      step();
      check("sticky_slow", 32'(slowdown), 32'(it == 1));
      check("sticky_speed", 32'(speedup), 32'(it == 2));
    end
    int_clr = 1'b1;
    step();
    int_clr = 1'b0;
    check("clr_slow", 32'(slowdown), 32'd0);
    check("clr_speed", 32'(speedup), 32'd0);
    check("holdoff_state", 32'(state), 32'd4);
    for (int k = 1; k <= ho; k++) begin
      step();
      check("holdoff_hold", 32'(state), 32'd4);
    end
    step();
    check("holdoff_exit", 32'(state), 32'd1);
  endtask

  initial begin
    int cl, cd, ch, nl, nd, nh, nloc, le, e, it, lc;
    tbl[0]  = '{64, 2, 10, 64, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{64, 2, 10, 64, 0, 0,  0, 0, 0, 0};
    tbl[2]  = '{64, 2, 10, 64, 0, 0,  0, 0, 0, 0};
    tbl[3]  = '{64, 2, 10, 64, 0, 0,  0, 0, 1, 0};
    tbl[4]  = '{64, 2, 10, 66, 0, 0,  2, 0, 1, 0};
    tbl[5]  = '{64, 2, 10, 70, 0, 0,  6, 1, 0, 100};
    tbl[6]  = '{64, 2,  3, 61, 0, 0, -3, 2, 0, 2};
    tbl[7]  = '{64, 2,  3, 62, 0, 0, -2, 0, 0, 0};
    tbl[8]  = '{ 0, 0,  0,  1, 0, 0,  0, 0, 0, 0};
    tbl[9]  = '{ 0, 0,  0,  2, 0, 0,  1, 1, 0, 0};
    tbl[10] = '{ 5, 0,  2,  5, 1, 1,  0, 0, 0, 0};
    tbl[11] = '{ 5, 0,  2,  5, 0, 0,  0, 0, 0, 0};
    tbl[12] = '{ 5, 0,  2,  4, 0, 0, -1, 2, 0, 3};

    rst = 1'b1; enable = 1'b1;
    master_edge = 1'b0; local_edge = 1'b0; int_clr = 1'b0;
    win_len = 16'(tbl[0].len); deadband = 8'(tbl[0].db); holdoff = 16'(tbl[0].ho);

    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_state", 32'(state), 32'd0);
      check("rst_slow", 32'(slowdown), 32'd0);
      check("rst_speed", 32'(speedup), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_valid", 32'(err_valid), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
    end
    rst = 1'b0;
    step();
    check("rst_release_state", 32'(state), 32'd1);

    for (int r = 0; r < 13; r++) begin
      if (r < 12) begin nl = tbl[r+1].len; nd = tbl[r+1].db; nh = tbl[r+1].ho; end
      else        begin nl = 8;            nd = 0;           nh = 3;           end
      window(tbl[r].len, tbl[r].nloc, tbl[r].coinc, tbl[r].eval_loc, nl, nd, nh,
             tbl[r].exp_err, tbl[r].exp_int, tbl[r].exp_lock);
      if (tbl[r].exp_int != 0) clear_seq(tbl[r].idle, tbl[r].ho, tbl[r].exp_int);
    end

    // Abort in MEASURE: lock first, then drop enable mid-window.
    for (int k = 0; k < 4; k++) window(8, 8, 0, 0, 8, 0, 3, 0, 0, k == 3);
    master_edge = 1'b1; local_edge = 1'b1; step();
    master_edge = 1'b0; step();
    local_edge = 1'b0; enable = 1'b0; step();
    check("abort_m_state", 32'(state), 32'd0);
    check("abort_m_slow", 32'(slowdown), 32'd0);
    check("abort_m_speed", 32'(speedup), 32'd0);
    check("abort_m_locked", 32'(locked), 32'd0);
    check("abort_m_err", 32'(err), 32'd0);
    enable = 1'b1; step();
    check("reenable_state", 32'(state), 32'd1);
    window(8, 8, 0, 0, 8, 0, 3, 0, 0, 0);

    // Abort in WAIT_CLR with a coincident clear.
    cl = $urandom_range(24, 0); cd = $urandom_range(6, 0); ch = $urandom_range(6, 0);
    window(8, 12, 0, 0, cl, cd, ch, 4, 1, 0);
    enable = 1'b0; int_clr = 1'b1; step();
    int_clr = 1'b0;
    check("abort_w_state", 32'(state), 32'd0);
    check("abort_w_slow", 32'(slowdown), 32'd0);
    check("abort_w_locked", 32'(locked), 32'd0);
    check("abort_w_err", 32'(err), 32'd4);
    enable = 1'b1; step();
    check("reenable2_state", 32'(state), 32'd1);
    m_lock = 0;

    for (int i = 0; i < 30; i++) begin
      le   = (cl == 0) ? 1 : cl;
      nloc = le + int'($urandom_range(16, 0)) - 8;
      if (nloc < 0) nloc = 0;
      if (i == 29) begin nl = 2; nd = 0; nh = 0; end
      else begin
        nl = $urandom_range(24, 0); nd = $urandom_range(6, 0); nh = $urandom_range(6, 0);
      end
      lc = (nloc > 65535) ? 65535 : nloc;
      e  = lc - le;
      it = (e > cd) ? 1 : ((e < -cd) ? 2 : 0);
      if (it != 0)     m_lock = 0;
      else if (m_lock < 4) m_lock++;
      window(cl, nloc, 0, 1'($urandom_range(1, 0)), nl, nd, nh, e, it, m_lock == 4);
      if (it != 0) clear_seq($urandom_range(4, 0), ch, it);
      cl = nl; cd = nd; ch = nh;
    end

    // Saturation: one long window flooded with local edges.
    window(2, 65540, 0, 0, 4, 0, 0, 65533, 1, 0);
    clear_seq(0, 0, 1);

    // Reset in the middle of a window discards it.
    master_edge = 1'b1; local_edge = 1'b1; step();
    master_edge = 1'b0; rst = 1'b1; step();
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    rst = 1'b0; local_edge = 1'b0; step();
    check("midrst_release", 32'(state), 32'd1);
    window(4, 4, 0, 0, 4, 0, 0, 0, 0, 0);

    enable = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fll_window_ctrl.md
# fll_window_ctrl

Measurement-window sequencer for the S3 FLL. It sits in the `WB_CLK` domain between the bit-clock edge detectors and the `FB_msg_out` interrupt lines. It counts local bit-clock edges over a window of N master bit-clock edges and converts the signed error into sticky speedup/slowdown interrupts for the M4, with deadband, software clear handshake, post-correction holdoff and lock detection. Firmware adjusts the `Sys_Clk1` divider in response to the interrupts; this block sequences when the next measurement may start.

## Interface

Parameters:
- `CNT_W`, 16, width of window, holdoff and edge counters.
- `LOCK_CNT`, 4, consecutive in-deadband windows required to assert `locked_o`.

Ports (clock and reset first):
- `WB_CLK`  in  1  — the single clock for all logic.
- `WB_RST`  in  1  — reset, synchronous and active-high.
- `enable_i`  in  1  — run/stop; low forces IDLE.
- `window_len_i`  in  CNT_W  — master edges per window; 0 is treated as 1.
- `deadband_i`  in  8  — allowed \|error\| without correction.
- `holdoff_i`  in  CNT_W  — `WB_CLK` cycles to wait after an interrupt clear.
- `master_edge_i`  in  1  — one-cycle pulse per master bit-clock rising edge, already in `WB_CLK` domain.
- `local_edge_i`  in  1  — one-cycle pulse per local bit-clock rising edge, already in `WB_CLK` domain.
- `int_clr_i`  in  1  — one-cycle firmware acknowledge of the pending interrupt.
- `Interrupt_speedup_o`  out  1  — level; local clock slow.
- `Interrupt_slowdown_o`  out  1  — level; local clock fast.
- `err_o`  out  CNT_W+1  — signed two's-complement error of the last window.
- `err_valid_o`  out  1  — one-cycle pulse when `err_o` updates.
- `locked_o`  out  1  — `LOCK_CNT` consecutive in-band windows seen.
- `state_o`  out  3  — FSM state for debug.

## Operation

- States and encodings: IDLE=0, MEASURE=1, EVAL=2, WAIT_CLR=3, HOLDOFF=4.
- Reset values: all outputs 0, state IDLE, all counters 0.
- `enable_i` low in any state moves to IDLE on the next cycle. It clears both interrupts, `locked_o`, the lock counter and the edge counters. `err_o` holds its last value.
- IDLE -> MEASURE when `enable_i`=1. Entering MEASURE:
  - samples `window_len_i`, `deadband_i` and `holdoff_i` into shadow registers, used until the next MEASURE entry;
  - clears `m_cnt` and `l_cnt`.
- MEASURE:
  - `m_cnt` increments on `master_edge_i`; `l_cnt` increments on `local_edge_i`.
  - `l_cnt` saturates at 2^CNT_W−1.
  - When `master_edge_i` arrives with `m_cnt`=len−1, the window closes. A `local_edge_i` in that same cycle is counted.
- Error: `err` = `l_cnt_final` − len, computed in CNT_W+1 bits, sign-extended.
- EVAL (exactly one cycle):
  - err > +deadband: set `Interrupt_slowdown_o`, go to WAIT_CLR.
  - err < −deadband: set `Interrupt_speedup_o`, go to WAIT_CLR.
  - otherwise: go to MEASURE, starting a fresh window.
  - Edges arriving during EVAL are discarded.
- Lock detection:
  - An in-band window increments the lock counter, saturating at `LOCK_CNT`. `locked_o` = (counter == `LOCK_CNT`).
  - An out-of-band window clears the counter and `locked_o` in the same cycle the interrupt sets.
- Interrupt rules:
  - At most one interrupt is ever high.
  - Interrupts are sticky until `int_clr_i` in WAIT_CLR, or until `enable_i` drops.
  - `int_clr_i` in any other state is ignored.
- WAIT_CLR: no counting. On `int_clr_i`, both interrupts drop on the next cycle and the FSM goes to HOLDOFF with `ho_cnt`=0.
- HOLDOFF: `ho_cnt` increments each cycle. When `ho_cnt`==holdoff, go to MEASURE on the next cycle. `holdoff_i`=0 gives a 1-cycle HOLDOFF.
- Simultaneous `int_clr_i` and `enable_i` falling: IDLE wins.
- `WB_RST` mid-window: counters are cleared and the partial window is discarded.

## Timing

- Window-closing master edge sampled at cycle T. At T+1: state=EVAL, `err_o` valid, `err_valid_o`=1 for one cycle.
- Interrupt output and `locked_o` change at T+2, together with the state going to WAIT_CLR or MEASURE.
- `int_clr_i` sampled at cycle C:
  - interrupts low and state=HOLDOFF at C+1;
  - state=MEASURE at C+2+holdoff.
- `state_o` is the registered state, with no added latency.
- `master_edge_i` pulses must be ≥2 `WB_CLK` cycles apart. Behaviour is undefined otherwise.

## Test plan

- Reset/idle: assert `WB_RST` for 3 cycles with `enable_i`=1 -> all outputs 0, `state_o`=0 during reset; `state_o`=1 in the cycle after reset releases.
- Exact match: len=64, deadband=2, 64 local edges per window -> `err_o`=0 each window, no interrupts; `locked_o`=1 at T+2 of the 4th window and stays high.
- Local fast: len=64, deadband=2, 70 local edges -> `err_o`=+6, `Interrupt_slowdown_o`=1 at T+2, `locked_o` cleared. The interrupt holds through 100 idle cycles. `int_clr_i` at C -> interrupt low at C+1; with holdoff=10, `state_o`=1 at C+12.
- Local slow at boundary: deadband=2 with 61 local edges -> `err_o`=−3, `Interrupt_speedup_o`=1. With 62 local edges -> −2, no interrupt.
- Edge cases:
  - window_len=0 behaves as 1;
  - a local edge coincident with the closing master edge is counted;
  - an edge during EVAL is dropped;
  - `int_clr_i` during MEASURE has no effect;
  - `l_cnt` saturates at 65535 with len=65535 and a continuous local pulse train.
- Abort: drop `enable_i` mid-MEASURE and, separately, in WAIT_CLR with `int_clr_i` in the same cycle -> IDLE next cycle, interrupts and `locked_o` low, `err_o` unchanged.
